multi_phase_signal_ctrl: RTL and testbench
==========================================

MULTI_PHASE_SIGNAL_CTRL -- requirements
Module: multi_phase_signal_ctrl

Interface
REQ-001 SHALL have parameter N_PHASES, default 4, number of signal phases (2..8).
REQ-002 SHALL have parameter CNT_W, default 8, dwell timer width; all timing parameters SHALL be < 2**CNT_W.
REQ-003 SHALL have parameter GREEN_MIN, default 4, minimum green dwell in cycles (>=1).
REQ-004 SHALL have parameter GREEN_MAX, default 10, maximum green dwell in cycles when other phases wait (>=GREEN_MIN).
REQ-005 SHALL have parameters YELLOW_T (default 2) and ALLRED_T (default 1), exact dwell in cycles (each >=1).
REQ-006 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port req  input  N_PHASES  per-phase demand; level, sampled every cycle.
REQ-009 SHALL have port light  output  2*N_PHASES  per-phase code at [2i+1:2i]: 0 green, 1 yellow, 2 red.
REQ-010 SHALL have port active_phase  output  $clog2(N_PHASES)  phase owning green/yellow.
REQ-011 SHALL have port phase_change  output  1  one-cycle pulse on the first green cycle of a new phase.

Function
REQ-012 SHALL implement FSM states GREEN, YELLOW, ALLRED with one dwell timer, cleared on every state entry.
REQ-013 SHALL set pending[i] on any cycle req[i]=1, and clear pending[i] on entry to GREEN of phase i (clear wins over set that cycle).
REQ-014 In GREEN, SHALL stay while timer < GREEN_MIN-1, or while no other phase is pending (rest in green, timer saturates).
REQ-015 In GREEN with another phase pending and minimum met, SHALL stay while req[active] holds and timer < GREEN_MAX-1, else go to YELLOW.
REQ-016 On entry to YELLOW, SHALL latch next phase as first pending phase searching round-robin from active_phase+1, wrapping at N_PHASES.
REQ-017 SHALL dwell exactly YELLOW_T cycles in YELLOW, then exactly ALLRED_T cycles in ALLRED, then enter GREEN of latched phase.
REQ-018 SHALL drive active phase light green in GREEN, yellow in YELLOW; all other phases, and all phases in ALLRED, red.
REQ-019 SHALL never show two non-red phases in the same cycle.
REQ-020 SHALL decode all outputs from registered state only (no combinational path from req to outputs).

Reset
REQ-021 On reset, SHALL enter GREEN, active_phase=0, timer=0, pending=0, phase_change=0; light = phase 0 green, others red, visible the cycle after reset.
REQ-022 Reset asserted in any state, including mid-YELLOW/ALLRED, SHALL take effect on the next clk edge, discarding the latched next phase.

Configuration
REQ-023 With PREEMPT_EN defined, SHALL add inputs preempt (1) and preempt_phase ($clog2(N_PHASES)) and output preempt_active (1, registered, reset 0).
REQ-024 Under PREEMPT_EN, preempt=1 in GREEN of another phase SHALL force YELLOW next cycle ignoring GREEN_MIN; next phase SHALL be preempt_phase regardless of pending; YELLOW/ALLRED dwells SHALL be unchanged.
REQ-025 Under PREEMPT_EN, preempt=1 in GREEN of preempt_phase SHALL hold green indefinitely, ignoring GREEN_MAX.
REQ-026 Without PREEMPT_EN, SHALL omit those ports and logic entirely.

Structure
REQ-027 SHALL place state enum and light codes (LT_GREEN=0, LT_YELLOW=1, LT_RED=2) in package signal_ctrl_pkg.
REQ-028 SHALL implement round-robin next-phase search as sub-module rr_phase_arbiter (pending, start index in; index, found out).

Verification (N_PHASES=4, GREEN_MIN=4, GREEN_MAX=10, YELLOW_T=2, ALLRED_T=1)
REQ-029 Reset, req=0 for 50 cycles -> light=8'b10_10_10_00 throughout, phase_change never pulses.
REQ-030 req[2] one-cycle pulse at cycle 0 after reset -> phase 0 green cycles 0-3, yellow 4-5, all red 6, phase 2 green cycle 7 with phase_change=1.
REQ-031 req[0] held, req[1] pulsed -> phase 0 green exactly 10 cycles, then yellow.
REQ-032 Active phase 1, pending {0,3} -> next green is phase 3, then phase 0.
REQ-033 Reset during second YELLOW cycle -> next cycle phase 0 green, pending=0.
REQ-034 PREEMPT_EN, phase 0 green at timer 1, preempt=1, preempt_phase=2 -> yellow next cycle, phase 2 green 3 cycles later, held past 10 cycles while preempt=1.

Source files
------------

// File: rtl/signal_ctrl_pkg.sv
// Shared types for the multi-phase signal controller: FSM states and per-phase light codes.
package signal_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    localparam logic [1:0] LT_GREEN  = 2'd0;
    localparam logic [1:0] LT_YELLOW = 2'd1;
    localparam logic [1:0] LT_RED    = 2'd2;
endpackage

// File: rtl/rr_phase_arbiter.sv
// Round-robin search: first set bit of pending at or after start, wrapping at N_PHASES.
module rr_phase_arbiter #(
    parameter int N_PHASES = 4,
    parameter int AW       = $clog2(N_PHASES)
) (
    input  logic [N_PHASES-1:0] pending,
    input  logic [AW-1:0]       start,
    output logic [AW-1:0]       index,
    output logic                found
);
    logic [2*N_PHASES-1:0] dbl;
    logic [2*N_PHASES-1:0] rot;
    logic [AW:0]           sum;

    assign dbl = {pending, pending};
    assign rot = dbl >> start;

    // Descending scan so the lowest offset from start wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        sum   = '0;
        for (int k = N_PHASES - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = (AW+1)'(start) + (AW+1)'(k);
                if (sum >= (AW+1)'(N_PHASES))
                    sum = sum - (AW+1)'(N_PHASES);
                index = sum[AW-1:0];
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/multi_phase_signal_ctrl.sv
// Multi-phase signal controller: GREEN/YELLOW/ALLRED sequencing with round-robin phase service.
// Optional preemption input set is enabled by defining PREEMPT_EN.
module multi_phase_signal_ctrl
    import signal_ctrl_pkg::*;
#(
    parameter int N_PHASES  = 4,
    parameter int CNT_W     = 8,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_PHASES-1:0]         req,
`ifdef PREEMPT_EN
    input  logic                        preempt,
    input  logic [$clog2(N_PHASES)-1:0] preempt_phase,
    output logic                        preempt_active,
`endif
    output logic [2*N_PHASES-1:0]       light,
    output logic [$clog2(N_PHASES)-1:0] active_phase,
    output logic                        phase_change
);
    localparam int AW = $clog2(N_PHASES);
    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);

    state_t              state, state_next;
    logic [CNT_W-1:0]    timer;
    logic [AW-1:0]       next_phase, sel_phase, arb_start, arb_idx;
    logic [N_PHASES-1:0] pending, others;
    logic                arb_found, go_yellow;

    // The active phase is masked out so "found" means some other phase is waiting.
    assign others    = pending & ~(N_PHASES'(1) << active_phase);
    assign arb_start = (active_phase == AW'(N_PHASES - 1)) ? '0 : active_phase + 1'b1;

    rr_phase_arbiter #(.N_PHASES(N_PHASES), .AW(AW)) u_arb (
        .pending (others),
        .start   (arb_start),
        .index   (arb_idx),
        .found   (arb_found)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_GREEN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        go_yellow  = 1'b0;
        sel_phase  = arb_idx;
        case (state)
            ST_GREEN: begin
                go_yellow = arb_found && (timer >= T_GMIN) &&
                            (!req[active_phase] || (timer >= T_GMAX));
`ifdef PREEMPT_EN
                if (preempt) begin
                    go_yellow = (preempt_phase != active_phase);
                    sel_phase = preempt_phase;
                end
`endif
                if (go_yellow) state_next = ST_YELLOW;
            end
            ST_YELLOW: if (timer >= T_Y)  state_next = ST_ALLRED;
            ST_ALLRED: if (timer >= T_AR) state_next = ST_GREEN;
            default:   state_next = ST_GREEN;
        endcase
    end

    always_comb begin
        light = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (state != ST_ALLRED && active_phase == AW'(i))
                light[2*i +: 2] = (state == ST_YELLOW) ? LT_YELLOW : LT_GREEN;
            else
                light[2*i +: 2] = LT_RED;
        end
    end

    // Timer restarts on every state change and saturates while resting in green.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            active_phase <= '0;
            next_phase   <= '0;
            pending      <= '0;
            phase_change <= 1'b0;
        end else begin
            phase_change <= 1'b0;
            pending      <= pending | req;
            if (state_next != state)  timer <= '0;
            else if (timer != '1)     timer <= timer + 1'b1;
            if (state == ST_GREEN && go_yellow)
                next_phase <= sel_phase;
            if (state == ST_ALLRED && state_next == ST_GREEN) begin
                active_phase <= next_phase;
                phase_change <= 1'b1;
                pending      <= (pending | req) & ~(N_PHASES'(1) << next_phase);
            end
        end
    end

`ifdef PREEMPT_EN
    always_ff @(posedge clk) begin
        if (reset) preempt_active <= 1'b0;
        else       preempt_active <= preempt;
    end
`endif
endmodule

// File: tb/tb_multi_phase_signal_ctrl.sv
// Self-checking bench for multi_phase_signal_ctrl (N_PHASES=4, default timing).
module tb_multi_phase_signal_ctrl;
    typedef struct {
        logic [3:0] req;
        logic [7:0] light;
        logic [1:0] ap;
        logic       pc;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = '0;
    logic [7:0] light;
    logic [1:0] active_phase;
    logic       phase_change;
`ifdef PREEMPT_EN
    logic       preempt = 1'b0;
    logic [1:0] preempt_phase = '0;
    logic       preempt_active;
`endif

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t vt[10];

    always #5 clk = ~clk;

    multi_phase_signal_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
`ifdef PREEMPT_EN
        .preempt        (preempt),
        .preempt_phase  (preempt_phase),
        .preempt_active (preempt_active),
`endif
        .light        (light),
        .active_phase (active_phase),
        .phase_change (phase_change)
    );

    // Expected light word: one phase showing code, the rest red; ph<0 gives all red.
    function automatic logic [7:0] lt(input int ph, input logic [1:0] code);
        logic [7:0] r;
        r = 8'hAA;
        if (ph >= 0) r[2*ph +: 2] = code;
        return r;
    endfunction

    // Called at a falling edge: score the current cycle, then drive req for it.
    task automatic apply(input string nm, input vec_t v);
        vec_t e;
        sb.push_back(v);
        e = sb.pop_front();
        checks++;
        if (light !== e.light || active_phase !== e.ap || phase_change !== e.pc) begin
            errors++;
            $display("FAIL %s t=%0t light=%h/%h active=%0d/%0d pc=%b/%b (got/exp)",
                     nm, $time, light, e.light, active_phase, e.ap, phase_change, e.pc);
        end
        req = v.req;
        @(negedge clk);
    endtask

    task automatic seg(input string nm, input int n, input logic [3:0] r0, input logic [3:0] r,
                       input int ph, input logic [1:0] code, input int ap, input bit pc);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.req   = (i == 0) ? r0 : r;
            v.light = lt(ph, code);
            v.ap    = 2'(ap);
            v.pc    = (i == 0) ? pc : 1'b0;
            apply(nm, v);
        end
    endtask

    // Leaves the bench at the falling edge of cycle 0 (first cycle after the reset edge).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{4'b0100, 8'hA8, 2'd0, 1'b0};
        vt[1] = '{4'b0000, 8'hA8, 2'd0, 1'b0};
        vt[2] = '{4'b0000, 8'hA8, 2'd0, 1'b0};
        vt[3] = '{4'b0000, 8'hA8, 2'd0, 1'b0};
        vt[4] = '{4'b0000, 8'hA9, 2'd0, 1'b0};
        vt[5] = '{4'b0000, 8'hA9, 2'd0, 1'b0};
        vt[6] = '{4'b0000, 8'hAA, 2'd0, 1'b0};
        vt[7] = '{4'b0000, 8'h8A, 2'd2, 1'b1};
        vt[8] = '{4'b0000, 8'h8A, 2'd2, 1'b0};
        vt[9] = '{4'b0000, 8'h8A, 2'd2, 1'b0};

        // Idle: phase 0 rests in green, no phase_change pulse.
        do_reset();
        seg("idle", 50, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b0);

        // Single pulse on phase 2.
        do_reset();
        for (int i = 0; i < 10; i++) apply("pulse2", vt[i]);

        // Phase 0 demand held: green runs to GREEN_MAX, then phase 1, then back to 0.
        do_reset();
        seg("max_g0", 10, 4'b0011, 4'b0001, 0, 2'd0, 0, 1'b0);
        seg("max_y0", 2, 4'b0001, 4'b0001, 0, 2'd1, 0, 1'b0);
        seg("max_ar", 1, 4'b0000, 4'b0000, -1, 2'd2, 0, 1'b0);
        seg("max_g1", 4, 4'b0000, 4'b0000, 1, 2'd0, 1, 1'b1);
        seg("max_y1", 2, 4'b0000, 4'b0000, 1, 2'd1, 1, 1'b0);
        seg("max_ar1", 1, 4'b0000, 4'b0000, -1, 2'd2, 1, 1'b0);
        seg("max_back0", 2, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b1);

        // Round robin from phase 1 with {0,3} pending: 3 first, then 0.
        do_reset();
        seg("rr_g0", 4, 4'b0010, 4'b0000, 0, 2'd0, 0, 1'b0);
        seg("rr_y0", 2, 4'b0000, 4'b0000, 0, 2'd1, 0, 1'b0);
        seg("rr_ar0", 1, 4'b0000, 4'b0000, -1, 2'd2, 0, 1'b0);
        seg("rr_g1", 4, 4'b1001, 4'b0000, 1, 2'd0, 1, 1'b1);
        seg("rr_y1", 2, 4'b0000, 4'b0000, 1, 2'd1, 1, 1'b0);
        seg("rr_ar1", 1, 4'b0000, 4'b0000, -1, 2'd2, 1, 1'b0);
        seg("rr_g3", 4, 4'b0000, 4'b0000, 3, 2'd0, 3, 1'b1);
        seg("rr_y3", 2, 4'b0000, 4'b0000, 3, 2'd1, 3, 1'b0);
        seg("rr_ar3", 1, 4'b0000, 4'b0000, -1, 2'd2, 3, 1'b0);
        seg("rr_g0b", 2, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b1);

        // Reset in the second yellow cycle discards the latched phase and pending demand.
        do_reset();
        seg("rst_g0", 4, 4'b0100, 4'b0000, 0, 2'd0, 0, 1'b0);
        seg("rst_y0", 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 1'b0);
        reset = 1'b1;
        seg("rst_y0b", 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 1'b0);
        reset = 1'b0;
        seg("rst_after", 8, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b0);

`ifdef PREEMPT_EN
        // Preempt to phase 2 from phase 0 at timer 1, then hold green past GREEN_MAX.
        do_reset();
        seg("pre_g0", 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b0);
        preempt = 1'b1;
        preempt_phase = 2'd2;
        seg("pre_g0t1", 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 1'b0);
        seg("pre_y0", 2, 4'b0000, 4'b0000, 0, 2'd1, 0, 1'b0);
        seg("pre_ar", 1, 4'b0000, 4'b0000, -1, 2'd2, 0, 1'b0);
        seg("pre_g2", 1, 4'b0001, 4'b0000, 2, 2'd0, 2, 1'b1);
        seg("pre_hold", 14, 4'b0000, 4'b0000, 2, 2'd0, 2, 1'b0);
        checks++;
        if (preempt_active !== 1'b1) begin
            errors++;
            $display("FAIL preempt_active got %b exp 1", preempt_active);
        end
        preempt = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
